// File: rtl/imem_loader_if.sv
// Control, byte-stream and instruction-memory write signals of the program loader.
// The loader takes the slave side; whatever drives the program image takes master.
interface imem_loader_if;
    logic        start;
    logic [6:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, err
    );

    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words and writes
// them to instruction memory, holding the core in reset until the load completes.
module imem_loader #(
    parameter int unsigned DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ASM_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    widx_q, widx_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [ASM_W-1:0]    asm_q, asm_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                core_reset_q, core_reset_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept_c;
    logic                start_ok_c;

    assign accept_c   = in_ready_q && bus.in_valid;
    assign start_ok_c = (bus.word_count != '0) && (32'(bus.word_count) <= DEPTH);

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        widx_d       = widx_q;
        bidx_d       = bidx_q;
        asm_d        = asm_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_reset_d = core_reset_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_ok_c) begin
                        count_d      = bus.word_count;
                        widx_d       = '0;
                        bidx_d       = '0;
                        core_reset_d = 1'b1;
                        state_d      = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept_c) begin
                    bidx_d = bidx_q + 2'd1;
                    unique case (bidx_q)
                        2'd0: asm_d[7:0]   = bus.in_data;
                        2'd1: asm_d[15:8]  = bus.in_data;
                        2'd2: asm_d[23:16] = bus.in_data;
                        default: begin
                            // Top byte completes the word; it goes straight to the write port.
                            we_d    = 1'b1;
                            wdata_d = {bus.in_data, asm_q};
                            addr_d  = ADDR_W'(widx_q);
                            widx_d  = widx_q + 7'd1;
                            if (widx_q == count_q - 7'd1) begin
                                state_d = FLUSH;
                                done_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            FLUSH: begin
                state_d      = IDLE;
                core_reset_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == LOAD);
    end

    // State and output registers; reset leaves the core held in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            widx_q       <= '0;
            bidx_q       <= '0;
            asm_q        <= '0;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            widx_q       <= widx_d;
            bidx_q       <= bidx_d;
            asm_q        <= asm_d;
            in_ready_q   <= in_ready_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_reset = core_reset_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams with random gaps, checked against
// word lists computed from the byte queue and the loader's handshake rules.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [7:0]  byte_q[$];
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    logic        done_we   = 1'b0;
    logic        done_rdy  = 1'b0;
    logic        cr_after  = 1'b1;
    logic        done_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observe the write port and pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            obs_addr.push_back(bus.imem_addr);
            obs_data.push_back(bus.imem_wdata);
        end
        if (done_prev) cr_after = bus.core_reset;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_we  = bus.imem_we;
            done_rdy = bus.in_ready;
        end
        if (bus.err === 1'b1) err_cnt++;
        done_prev = (bus.done === 1'b1);
    end

    task automatic fill_rand(input int n);
        byte_q.delete();
        repeat (n) byte_q.push_back(8'($urandom));
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        done_we  = 1'b0;
        done_rdy = 1'b1;
        cr_after = 1'b1;
    endtask

    task automatic do_start(input int cnt);
        bus.start      = 1'b1;
        bus.word_count = 7'(cnt);
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.word_count = 7'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int waited = 0;
        repeat ($urandom_range(gap_max, 0)) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) chk("rdy_timeout", 64'd0, 64'd1);
        else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy"},   64'(bus.in_ready),   64'd0);
        chk({tag, "_we"},    64'(bus.imem_we),    64'd0);
        chk({tag, "_done"},  64'(bus.done),       64'd0);
        chk({tag, "_err"},   64'(bus.err),        64'd0);
        chk({tag, "_addr"},  64'(bus.imem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
        chk({tag, "_cr"},    64'(bus.core_reset), 64'd1);
    endtask

    // Expected writes: word i is bytes 4i..4i+3, least significant first.
    task automatic check_load(input int cnt, input int d0);
        logic [31:0] w;
        chk("n_writes", 64'(obs_addr.size()), 64'(cnt));
        for (int i = 0; i < obs_addr.size() && i < cnt; i++) begin
            w = 32'(byte_q[4*i]) | (32'(byte_q[4*i+1]) << 8) |
                (32'(byte_q[4*i+2]) << 16) | (32'(byte_q[4*i+3]) << 24);
            chk("waddr", 64'(obs_addr[i]), 64'(i));
            chk("wdata", 64'(obs_data[i]), 64'(w));
        end
        chk("done_once",     64'(done_cnt - d0), 64'd1);
        chk("done_with_we",  64'(done_we),       64'd1);
        chk("rdy_in_flush",  64'(done_rdy),      64'd0);
        chk("cr_after_done", 64'(cr_after),      64'd0);
    endtask

    task automatic run_load(input int cnt, input int gap_max);
        int d0;
        if (byte_q.size() != 4*cnt) fill_rand(4*cnt);
        clear_obs();
        d0 = done_cnt;
        do_start(cnt);
        chk("cr_in_load",  64'(bus.core_reset), 64'd1);
        chk("rdy_in_load", 64'(bus.in_ready),   64'd1);
        for (int i = 0; i < byte_q.size(); i++) send_byte(byte_q[i], gap_max);
        repeat (3) @(negedge clk);
        #1;
        check_load(cnt, d0);
    endtask

    task automatic bad_start(input int cnt, input logic exp_cr);
        int e0 = err_cnt;
        clear_obs();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        do_start(cnt);
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("err_pulse",   64'(err_cnt - e0),      64'd1);
        chk("err_nowrite", 64'(obs_addr.size()),   64'd0);
        chk("err_cr",      64'(bus.core_reset),    64'(exp_cr));
        chk("err_idle",    64'(bus.in_ready),      64'd0);
    endtask

    initial begin
        int d0;
        int e0;
        int cnt;
        int nb;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("in_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("post_rst");

        // Rejected starts right after reset leave the core held.
        bad_start(0, 1'b1);
        bad_start(65, 1'b1);
        bad_start(127, 1'b1);

        // Single known instruction.
        byte_q = '{8'h93, 8'h00, 8'h50, 8'h00};
        run_load(1, 0);
        if (obs_data.size() > 0) chk("single_word", 64'(obs_data[0]), 64'h0000_0000_0050_0093);

        // Three words with random stalls.
        fill_rand(12);
        run_load(3, 3);

        // Rejected start after a completed load keeps core_reset low.
        bad_start(0, 1'b0);

        // Start while loading is ignored.
        fill_rand(8);
        clear_obs();
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(2);
        for (int i = 0; i < 3; i++) send_byte(byte_q[i], 1);
        do_start(5);
        for (int i = 3; i < 8; i++) send_byte(byte_q[i], 1);
        repeat (3) @(negedge clk);
        #1;
        check_load(2, d0);
        chk("start_in_load_err", 64'(err_cnt - e0), 64'd0);

        // Reset in the middle of a load aborts without a clock edge.
        for (int k = 0; k < 2; k++) begin
            cnt = (k == 0) ? 2 : 3;
            nb  = (k == 0) ? 6 : 8;
            fill_rand(4*cnt);
            clear_obs();
            d0 = done_cnt;
            do_start(cnt);
            for (int i = 0; i < nb; i++) send_byte(byte_q[i], 1);
            if (k == 1) chk("we_before_rst", 64'(bus.imem_we), 64'd1);
            rst = 1'b1;
            #1;
            chk("abort_we",  64'(bus.imem_we),    64'd0);
            chk("abort_rdy", 64'(bus.in_ready),   64'd0);
            chk("abort_cr",  64'(bus.core_reset), 64'd1);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk); #1;
            check_reset_vals("abort");
            chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        end
        run_load(2, 1);

        // Random loads.
        repeat (4) begin
            cnt = int'($urandom_range(8, 1));
            fill_rand(4*cnt);
            run_load(cnt, 2);
        end

        // Full depth.
        fill_rand(4*DEPTH);
        run_load(DEPTH, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, default 64, number of 32-bit instruction memory words.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 word_count  input  7  number of words to load; sampled only on an accepted start.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data, little-endian within each word.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-010 imem_addr  output  32  word index written; matches the instruction memory word-indexed address.
REQ-011 imem_wdata  output  32  assembled instruction word.
REQ-012 core_reset  output  1  holds the core (PC, register file) in reset while high.
REQ-013 done  output  1  one-cycle pulse on completion of a load.
REQ-014 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-015 States: IDLE, LOAD, FLUSH.
REQ-016 Byte transfer: a byte is accepted on the posedge where in_valid and in_ready are both 1.
- in_ready = 1 only in LOAD; in_data is ignored otherwise.
REQ-017 IDLE, start with 1 <= word_count <= DEPTH:
- latch word_count.
- clear the word index and byte index to 0.
- set core_reset to 1.
- go to LOAD next cycle.
REQ-018 IDLE, start with word_count = 0 or word_count > DEPTH:
- pulse err for the next cycle.
- remain in IDLE.
- leave core_reset unchanged.
REQ-019 start asserted in LOAD or FLUSH: ignored, no err pulse.
REQ-020 Byte placement: the byte accepted with byte index b (0..3) is placed in word bits [8b+7:8b].
- byte index increments modulo 4 on each accepted byte.
REQ-021 Word write: on the edge accepting byte index 3:
- the next cycle has imem_we = 1.
- imem_wdata = the full assembled word.
- imem_addr = the current word index, zero-extended.
- the word index then increments.
REQ-022 imem_we is registered and is high for exactly one cycle per completed word.
- Outputs hold valid write data and address during that cycle.
REQ-023 Last byte of word number latched_count-1 accepted:
- go to FLUSH (the cycle carrying the final imem_we).
- in_ready = 0 in FLUSH.
REQ-024 FLUSH lasts one cycle:
- done = 1 in that cycle.
- next cycle: IDLE with core_reset = 0.
REQ-025 A byte stream that stalls (in_valid = 0) holds all state indefinitely; there is no timeout.
REQ-026 Partial words never produce imem_we.
REQ-027 A reload (new accepted start after a completed load) re-asserts core_reset the next cycle and overwrites from word 0.
REQ-028 Words at index >= latched word_count are never written.

Reset
REQ-029 While reset is high, and on the cycle after release:
- state = IDLE.
- in_ready = 0, imem_we = 0, done = 0, err = 0.
- imem_addr = 0, imem_wdata = 0.
- core_reset = 1.
- word and byte indices = 0.
REQ-030 Reset asserted mid-load aborts immediately, without waiting for a clock:
- imem_we deasserts.
- no done pulse is produced.
- core_reset stays 1 until a later load completes.

Verification
REQ-031 Single word: start, word_count=1, bytes 0x93,0x00,0x50,0x00 -> one imem_we with addr 0, wdata 0x00500093; done coincident; core_reset = 0 the next cycle.
REQ-032 Three words with random in_valid gaps -> exactly 3 imem_we pulses, addr 0,1,2 in order, data little-endian assembled; in_ready = 0 in FLUSH.
REQ-033 start with word_count=0, then 65 -> one err pulse each; state IDLE; no imem_we; core_reset stays 1.
REQ-034 start during LOAD with word_count=5 (original 2) -> ignored; load completes after 8 bytes with 2 writes.
REQ-035 reset asserted after 6 of 8 bytes -> imem_we = 0 at once, no done; core_reset = 1; next full load writes from addr 0.
REQ-036 Full DEPTH=64 load -> last imem_we with addr 63; no write with addr 64; done once.
